// File: rtl/aes_inv_key_sched_128_pkg.sv
// Shared definitions for the AES-128 inverse key schedule: controller states,
// round count and the round-constant lookup.
package aes_inv_key_sched_128_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } ks_state_e;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Round constant for round index 1..10; every other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_rot_subword.sv
// SubWord(RotWord(x)) built from four S-box cells; byte 3 is the MSB.
module aes_rot_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] rot;

    assign rot = {word_i[23:0], word_i[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_i  (rot[8*gi +: 8]),
                .out_o (word_o[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box cell: multiplicative inverse in GF(2^8) followed by the
// affine transform, all combinational.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 is the inverse of x (and maps 0 to 0): product of x^(2^k), k=1..7.
    always_comb begin
        sq  = in_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_sched_128.sv
// AES-128 key schedule that expands the cipher key forward to round 10, then
// streams round keys 10..0 over a valid/ready handshake, one per cycle.
module aes_inv_key_sched_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         done
);

    import aes_inv_key_sched_128_pkg::*;

    ks_state_e    state_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         last_q;
    logic         done_q;
    logic         busy_q;

    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  sw_in, sw_out, rcon_word;
    logic [3:0]   rcon_idx;
    logic         emit_sel;
    logic [127:0] fwd_key_d, inv_key_d;
    logic [31:0]  w4, w5, w6, w7;
    logic [31:0]  b0, b1, b2, b3;

    assign a0 = rk_q[127:96];
    assign a1 = rk_q[95:64];
    assign a2 = rk_q[63:32];
    assign a3 = rk_q[31:0];

    // The single S-box word unit sees w3 while expanding and a3^a2 while emitting.
    assign emit_sel  = (state_q == ST_EMIT);
    assign sw_in     = emit_sel ? (a3 ^ a2) : a3;
    assign rcon_idx  = emit_sel ? round_q : 4'(round_q + 4'd1);
    assign rcon_word = {rcon(rcon_idx), 24'h000000};

    aes_rot_subword u_rot_subword (
        .word_i (sw_in),
        .word_o (sw_out)
    );

    assign w4 = a0 ^ sw_out ^ rcon_word;
    assign w5 = w4 ^ a1;
    assign w6 = w5 ^ a2;
    assign w7 = w6 ^ a3;
    assign fwd_key_d = {w4, w5, w6, w7};

    assign b3 = a3 ^ a2;
    assign b2 = a2 ^ a1;
    assign b1 = a1 ^ a0;
    assign b0 = a0 ^ sw_out ^ rcon_word;
    assign inv_key_d = {b0, b1, b2, b3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Holding off start during the done pulse keeps start and done disjoint.
                    if (start && !done_q) begin
                        rk_q    <= key;
                        round_q <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    rk_q    <= fwd_key_d;
                    round_q <= 4'(round_q + 4'd1);
                    if (round_q == NUM_ROUNDS - 4'd1) begin
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (round_q == 4'd0) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            rk_q    <= inv_key_d;
                            round_q <= 4'(round_q - 4'd1);
                            last_q  <= (round_q == 4'd1);
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk       = rk_q;
    assign rk_round = round_q;
    assign rk_valid = valid_q;
    assign rk_last  = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched_128.sv
// Bench for the inverse key schedule: known-answer table plus random keys,
// checked against a forward FIPS-197 key expansion model.
module tb_aes_inv_key_sched_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk   [11];
    logic [127:0] got_rk   [11];

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [7];

    aes_inv_key_sched_128 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
    endfunction

    // Standard forward expansion of all 44 words; round key r = words 4r..4r+3.
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_rot(t) ^ {rc, 24'h000000};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full schedule request; called and returning at #1 after a rising edge.
    task automatic run_seq(input logic [127:0] k, input int stall_round, input int stall_cycles,
                           input bit poke, input bit rand_stall, input int abort_round);
        logic [127:0] other;
        int cyc;
        int r;
        int stalls;
        int guard;
        build_model(k);
        other = ~k ^ 128'h5a5a;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = other;
        cyc   = 1;
        check("busy_after_start", 128'(busy), 128'(1));
        while (!rk_valid && cyc < 40) begin
            start = (poke && cyc == 4);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("first_valid_cycle", 128'(cyc), 128'(11));
        if (!rk_valid) return;
        r      = 10;
        stalls = stall_cycles;
        guard  = 0;
        while (r >= 0 && guard < 200) begin
            guard++;
            check("rk_valid", 128'(rk_valid), 128'(1));
            check("rk_round", 128'(rk_round), 128'(r));
            check("rk", rk, exp_rk[r]);
            check("rk_last", 128'(rk_last), 128'(r == 0));
            check("busy_emit", 128'(busy), 128'(1));
            got_rk[r] = rk;
            if (r == abort_round) begin
                rst_n = 1'b0;
                #1;
                check("rst_rk", rk, 128'(0));
                check("rst_rk_round", 128'(rk_round), 128'(0));
                check("rst_outputs", 128'({rk_valid, rk_last, done, busy}), 128'(0));
                @(posedge clk); @(posedge clk); #1;
                check("rst_held_valid", 128'(rk_valid), 128'(0));
                rst_n    = 1'b1;
                rk_ready = 1'b1;
                $display("seq key=%h aborted by reset at round %0d", k, r);
                return;
            end
            key   = (poke && r == 8) ? other : key;
            start = (poke && r == 8);
            if (r == stall_round && stalls > 0) begin
                rk_ready = 1'b0;
                stalls--;
            end else if (rand_stall && $urandom_range(0, 2) == 0) begin
                rk_ready = 1'b0;
            end else begin
                rk_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (rk_ready) r--;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        check("emit_complete", 128'(r < 0), 128'(1));
        check("done_pulse", 128'(done), 128'(1));
        check("idle_after_last", 128'({rk_valid, busy}), 128'(0));
        @(posedge clk); #1;
        check("done_single", 128'(done), 128'(0));
        $display("seq key=%h beats=%0d latency=%0d", k, guard, cyc);
    endtask

    initial begin
        logic [127:0] fips;
        logic [127:0] rkey;
        fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[0] = '{key: fips,   round: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{key: fips,   round: 9,  rk: 128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{key: fips,   round: 1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[3] = '{key: fips,   round: 0,  rk: fips};
        vecs[4] = '{key: 128'h0, round: 10, rk: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[5] = '{key: 128'h0, round: 1,  rk: 128'h62636363626363636263636362636363};
        vecs[6] = '{key: 128'h0, round: 0,  rk: 128'h0};

        build_sbox();
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rk", rk, 128'(0));
        check("reset_ctrl", 128'({rk_round, rk_valid, rk_last, done, busy}), 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key)
                run_seq(vecs[i].key, -1, 0, 1'b0, 1'b0, -1);
            check($sformatf("vec%0d_round%0d", i, vecs[i].round), got_rk[vecs[i].round], vecs[i].rk);
        end

        run_seq(fips, 7, 5, 1'b0, 1'b0, -1);
        run_seq(fips, -1, 0, 1'b1, 1'b0, -1);

        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_seq(rkey, -1, 0, 1'b0, 1'b0, 4);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_seq(rkey, -1, 0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_seq(rkey, -1, 0, 1'b0, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_sched_128.md
AES_INV_KEY_SCHED_128 -- requirements
Module: aes_inv_key_sched_128

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new schedule; honoured only in IDLE.
REQ-004 SHALL have port key, input, 128 bits: AES-128 cipher key, word w0 = [127:96], sampled when start is honoured.
REQ-005 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-006 SHALL have port rk, output, 128 bits: current round key, same word order as key.
REQ-007 SHALL have port rk_round, output, 4 bits: round index of rk (10 down to 0).
REQ-008 SHALL have port rk_valid, output, 1 bit: rk/rk_round are valid.
REQ-009 SHALL have port rk_ready, input, 1 bit: consumer accepts rk this cycle.
REQ-010 SHALL have port rk_last, output, 1 bit: high with rk_valid when rk_round = 0.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after round key 0 is accepted.

Function
REQ-012 SHALL implement states IDLE, EXPAND and EMIT.
REQ-013 SHALL, in IDLE with start = 1, load key into the key register, set the round counter to 0 and enter EXPAND.
REQ-014 SHALL, in EXPAND, compute one forward round per cycle: w4 = w0^SubWord(RotWord(w3))^{rcon(r),24'b0}, then w5 = w4^w1, w6 = w5^w2, w7 = w6^w3, for r = 1..10.
REQ-015 SHALL enter EMIT after exactly 10 EXPAND cycles, with the register holding round key 10 and rk_round = 10.
REQ-016 SHALL assert rk_valid in EMIT only; first rk_valid occurs 11 cycles after the start cycle.
REQ-017 SHALL hold rk, rk_round and rk_valid stable while rk_valid = 1 and rk_ready = 0.
REQ-018 SHALL, on a handshake (rk_valid & rk_ready) with rk_round = r > 0, load round key r-1 in the same edge and decrement rk_round.
REQ-019 SHALL compute round key r-1 from round key r (a0..a3) as: b3 = a3^a2, b2 = a2^a1, b1 = a1^a0, b0 = a0^SubWord(RotWord(b3))^{rcon(r),24'b0}.
REQ-020 SHALL use rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36; rcon of any other index = 00.
REQ-021 SHALL sustain one round key per cycle when rk_ready is held high (11 consecutive valid beats).
REQ-022 SHALL, on a handshake with rk_round = 0, return to IDLE and pulse done for the following cycle.
REQ-023 SHALL ignore start while busy = 1; start and done in the same cycle SHALL NOT be possible.
REQ-024 SHALL share one RotWord/SubWord unit between EXPAND and EMIT, steered by state.

Reset
REQ-025 SHALL, on rst_n = 0, asynchronously force state IDLE, rk = 0, rk_round = 0, and rk_valid, rk_last, done and busy = 0.
REQ-026 SHALL abandon any in-progress expansion or emission on reset; no partial output SHALL appear after release.
REQ-027 SHALL accept start on the first clock edge after reset release.

Structure
REQ-028 SHALL place the state enumeration, the round count constant (10) and the rcon lookup function in a shared AES package.
REQ-029 SHALL use one sub-module, aes_rot_subword, that instantiates four existing sbox cells and computes SubWord(RotWord(x)).
REQ-030 SHALL NOT use more than four sbox instances in total.

Verification
REQ-031 SHALL cover the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready held at 1:
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
- round 9 = ac7766f319fadc2128d12941575c006e;
- round 1 = a0fafe1788542cb123a339392a6c7605;
- round 0 = the key, with rk_last = 1;
- done pulses one cycle later.
REQ-032 SHALL cover the all-zero key:
- round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
- round 1 = 62636363626363636263636362636363;
- round 0 = 0.
REQ-033 SHALL cover backpressure: rk_ready low for 5 cycles while rk_round = 7 -> rk and rk_round unchanged for those cycles, and the sequence continues correctly afterwards.
REQ-034 SHALL cover start pulsed during EXPAND and during EMIT with a different key -> ignored; the output sequence matches the original key.
REQ-035 SHALL cover rst_n asserted while rk_round = 4 -> all outputs 0 immediately; a new start then yields a correct full sequence with first rk_valid 11 cycles after start.
